// File: rtl/fwd_hazard_unit_if.sv
// Port bundle for fwd_hazard_unit: EX/ID pipeline inputs in, operand forwards and stall
// controls out. The pipeline side uses master and the hazard unit uses slave.
interface fwd_hazard_unit_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned CNT_W   = 16
);
   logic [31:0]               exInstr;
   logic [31:0]               idInstr;
   logic [NUM_FWD*REG_W-1:0]  destVec;
   logic [NUM_FWD-1:0]        regWriteVec;
   logic [NUM_FWD*DATA_W-1:0] resultVec;
   logic [REG_W-1:0]          exDest;
   logic                      exMemRead;
   logic                      cntClear;
   logic [SEL_W-1:0]          fwdSelA;
   logic [SEL_W-1:0]          fwdSelB;
   logic [DATA_W-1:0]         fwdValA;
   logic [DATA_W-1:0]         fwdValB;
   logic                      stall;
   logic                      bubble;
   logic [CNT_W-1:0]          stallCnt;
   logic [CNT_W-1:0]          fwdCnt;

   modport master (
      output exInstr, idInstr, destVec, regWriteVec, resultVec, exDest, exMemRead, cntClear,
      input  fwdSelA, fwdSelB, fwdValA, fwdValB, stall, bubble, stallCnt, fwdCnt
   );

   modport slave (
      input  exInstr, idInstr, destVec, regWriteVec, resultVec, exDest, exMemRead, cntClear,
      output fwdSelA, fwdSelB, fwdValA, fwdValB, stall, bubble, stallCnt, fwdCnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// N-stage EX operand forwarding selector plus load-use stall sequencer for the ID stage,
// with saturating stall/forward event counters for performance debug.
module fwd_hazard_unit #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned NUM_FWD    = 2,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned LOAD_STALL = 1,
   parameter int unsigned CNT_W      = 16
) (
   input logic              Clk,
   input logic              Rst,
   fwd_hazard_unit_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StStall} state_e;

   // The detection cycle is the first stall cycle, so StStall lasts LOAD_STALL-1 cycles.
   localparam int unsigned StallLoad = (LOAD_STALL > 1) ? LOAD_STALL - 2 : 0;
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   // Returns {rs_used, rt_used} for a 6-bit opcode.
   function automatic logic [1:0] op_use(input logic [5:0] op);
      logic [1:0] u;
      case (op)
         6'b100011, 6'b100000, 6'b100001, 6'b001000,
         6'b001100, 6'b001101, 6'b001110, 6'b001010: u = 2'b10;
         6'b000000, 6'b011100, 6'b101011, 6'b101001,
         6'b101000, 6'b000100, 6'b000101:            u = 2'b11;
         default:                                    u = 2'b00;
      endcase
      return u;
   endfunction

   logic [1:0]       ex_use;
   logic [1:0]       id_use;
   logic [REG_W-1:0] ex_rs;
   logic [REG_W-1:0] ex_rt;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             unused_bits;

   assign ex_use = op_use(bus.exInstr[31:26]);
   assign id_use = op_use(bus.idInstr[31:26]);
   assign ex_rs  = REG_W'(bus.exInstr[25:21]);
   assign ex_rt  = REG_W'(bus.exInstr[20:16]);
   assign id_rs  = REG_W'(bus.idInstr[25:21]);
   assign id_rt  = REG_W'(bus.idInstr[20:16]);
   assign unused_bits = ^{bus.exInstr[15:0], bus.idInstr[15:0]};

   // ---------------------------------------------------------------------------------------
   // Forwarding selection
   // ---------------------------------------------------------------------------------------
   logic [SEL_W-1:0]  sel_a;
   logic [SEL_W-1:0]  sel_b;
   logic [DATA_W-1:0] val_a;
   logic [DATA_W-1:0] val_b;
   logic              hit_a;
   logic              hit_b;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      val_a = '0;
      val_b = '0;
      hit_a = 1'b0;
      hit_b = 1'b0;
      // Ascending scan; the first hit latches so the nearest stage wins.
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
         if (!hit_a && ex_use[1] && (ex_rs != '0) && bus.regWriteVec[k] &&
             (bus.destVec[k*REG_W +: REG_W] == ex_rs)) begin
            hit_a = 1'b1;
            sel_a = SEL_W'(k + 1);
            val_a = bus.resultVec[k*DATA_W +: DATA_W];
         end
         if (!hit_b && ex_use[0] && (ex_rt != '0) && bus.regWriteVec[k] &&
             (bus.destVec[k*REG_W +: REG_W] == ex_rt)) begin
            hit_b = 1'b1;
            sel_b = SEL_W'(k + 1);
            val_b = bus.resultVec[k*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.fwdSelA = sel_a;
   assign bus.fwdSelB = sel_b;
   assign bus.fwdValA = val_a;
   assign bus.fwdValB = val_b;

   // ---------------------------------------------------------------------------------------
   // Load-use hazard and stall FSM
   // ---------------------------------------------------------------------------------------
   logic   hazard;
   state_e state_q;
   state_e state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic   stall_raw;
   logic   stall;

   assign hazard = bus.exMemRead && (bus.exDest != '0) &&
                   ((id_use[1] && (id_rs == bus.exDest)) ||
                    (id_use[0] && (id_rt == bus.exDest)));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            // A one-cycle stall is fully covered by the detection cycle.
            if (hazard && (LOAD_STALL > 1)) begin
               state_d = StStall;
               cnt_d   = 4'(StallLoad);
            end
         end
         StStall: begin
            if (cnt_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_raw = 1'b0;
      unique case (state_q)
         StIdle:  stall_raw = hazard;
         StStall: stall_raw = 1'b1;
         default: stall_raw = 1'b0;
      endcase
   end

   // Gated by reset so the outputs drop at once, even mid-stall.
   assign stall      = stall_raw & Rst;
   assign bus.stall  = stall;
   assign bus.bubble = stall;

   // ---------------------------------------------------------------------------------------
   // Saturating performance counters
   // ---------------------------------------------------------------------------------------
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] fwd_cnt_q;
   logic [CNT_W-1:0] fwd_cnt_d;
   logic             fwd_active;

   assign fwd_active = (sel_a != '0) || (sel_b != '0);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (bus.cntClear) begin
         stall_cnt_d = '0;
         fwd_cnt_d   = '0;
      end else begin
         if (stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (fwd_active && (fwd_cnt_q != CntMax)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign bus.stallCnt = stall_cnt_q;
   assign bus.fwdCnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_STALL=1/CNT_W=16 and LOAD_STALL=3/CNT_W=4)
// share stimulus; directed scenarios then random cycles against a behavioural model.
module tb_fwd_hazard_unit;
   localparam int unsigned DW   = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned NF   = 3;
   localparam int unsigned SW   = 2;
   localparam int unsigned LS_A = 1;
   localparam int unsigned LS_B = 3;
   localparam int          MAX_A = 65535;
   localparam int          MAX_B = 15;

   logic Clk;
   logic Rst;
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [31:0]      ex_instr;
   logic [31:0]      id_instr;
   logic [NF*RW-1:0] dest_vec;
   logic [NF-1:0]    rw_vec;
   logic [NF*DW-1:0] res_vec;
   logic [RW-1:0]    ex_dest;
   logic             ex_mem_read;
   logic             cnt_clear;

   fwd_hazard_unit_if #(.DATA_W(DW), .REG_W(RW), .NUM_FWD(NF), .SEL_W(SW), .CNT_W(16)) if_a ();
   fwd_hazard_unit_if #(.DATA_W(DW), .REG_W(RW), .NUM_FWD(NF), .SEL_W(SW), .CNT_W(4))  if_b ();

   assign if_a.exInstr     = ex_instr;
   assign if_a.idInstr     = id_instr;
   assign if_a.destVec     = dest_vec;
   assign if_a.regWriteVec = rw_vec;
   assign if_a.resultVec   = res_vec;
   assign if_a.exDest      = ex_dest;
   assign if_a.exMemRead   = ex_mem_read;
   assign if_a.cntClear    = cnt_clear;
   assign if_b.exInstr     = ex_instr;
   assign if_b.idInstr     = id_instr;
   assign if_b.destVec     = dest_vec;
   assign if_b.regWriteVec = rw_vec;
   assign if_b.resultVec   = res_vec;
   assign if_b.exDest      = ex_dest;
   assign if_b.exMemRead   = ex_mem_read;
   assign if_b.cntClear    = cnt_clear;

   fwd_hazard_unit #(
      .DATA_W(DW), .REG_W(RW), .NUM_FWD(NF), .SEL_W(SW), .LOAD_STALL(LS_A), .CNT_W(16)
   ) u_a (
      .Clk(Clk),
      .Rst(Rst),
      .bus(if_a)
   );

   fwd_hazard_unit #(
      .DATA_W(DW), .REG_W(RW), .NUM_FWD(NF), .SEL_W(SW), .LOAD_STALL(LS_B), .CNT_W(4)
   ) u_b (
      .Clk(Clk),
      .Rst(Rst),
      .bus(if_b)
   );

   int n_total;
   int n_bad;
   int left_a, left_b;            // stall cycles still owed after the current one
   int scnt_a, fcnt_a, scnt_b, fcnt_b;
   bit exp_hz, exp_st_a, exp_st_b;
   int exp_sa, exp_sb;
   logic [5:0] ops [17];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic op_use(input logic [5:0] op, output bit urs, output bit urt);
      urs = 1'b0;
      urt = 1'b0;
      foreach (ops[i]) begin
         if (ops[i] == op) begin
            urs = (i < 15);
            urt = (i >= 8) && (i < 15);
         end
      end
   endtask

   task automatic fwd_ref(input logic [4:0] r, input bit used, output int sel,
                          output logic [31:0] val);
      sel = 0;
      val = '0;
      if (used && r != 0) begin
         for (int k = 0; k < NF; k++) begin
            if (sel == 0 && rw_vec[k] && dest_vec[k*RW +: RW] == r) begin
               sel = k + 1;
               val = res_vec[k*DW +: DW];
            end
         end
      end
   endtask

   task automatic cmp_now();
      bit urs, urt, irs, irt;
      logic [31:0] va, vb;
      #1;
      op_use(ex_instr[31:26], urs, urt);
      fwd_ref(ex_instr[25:21], urs, exp_sa, va);
      fwd_ref(ex_instr[20:16], urt, exp_sb, vb);
      op_use(id_instr[31:26], irs, irt);
      exp_hz = ex_mem_read && (ex_dest != 0) &&
               ((irs && id_instr[25:21] == ex_dest) || (irt && id_instr[20:16] == ex_dest));
      exp_st_a = Rst && (left_a > 0 || exp_hz);
      exp_st_b = Rst && (left_b > 0 || exp_hz);
      check_eq("selA_a", 64'(if_a.fwdSelA), 64'(exp_sa));
      check_eq("selB_a", 64'(if_a.fwdSelB), 64'(exp_sb));
      check_eq("valA_a", 64'(if_a.fwdValA), 64'(va));
      check_eq("valB_a", 64'(if_a.fwdValB), 64'(vb));
      check_eq("selA_b", 64'(if_b.fwdSelA), 64'(exp_sa));
      check_eq("selB_b", 64'(if_b.fwdSelB), 64'(exp_sb));
      check_eq("valA_b", 64'(if_b.fwdValA), 64'(va));
      check_eq("valB_b", 64'(if_b.fwdValB), 64'(vb));
      check_eq("stall_a", 64'(if_a.stall), 64'(exp_st_a));
      check_eq("bubble_a", 64'(if_a.bubble), 64'(exp_st_a));
      check_eq("stall_b", 64'(if_b.stall), 64'(exp_st_b));
      check_eq("bubble_b", 64'(if_b.bubble), 64'(exp_st_b));
   endtask

   task automatic tick();
      bit fon;
      fon = (exp_sa != 0) || (exp_sb != 0);
      @(posedge Clk);
      if (cnt_clear) begin
         scnt_a = 0; fcnt_a = 0; scnt_b = 0; fcnt_b = 0;
      end else begin
         if (exp_st_a && scnt_a < MAX_A) scnt_a++;
         if (fon && fcnt_a < MAX_A) fcnt_a++;
         if (exp_st_b && scnt_b < MAX_B) scnt_b++;
         if (fon && fcnt_b < MAX_B) fcnt_b++;
      end
      if (left_a > 0) left_a--;
      else if (exp_hz) left_a = LS_A - 1;
      if (left_b > 0) left_b--;
      else if (exp_hz) left_b = LS_B - 1;
      #1;
      check_eq("stallCnt_a", 64'(if_a.stallCnt), 64'(scnt_a));
      check_eq("fwdCnt_a", 64'(if_a.fwdCnt), 64'(fcnt_a));
      check_eq("stallCnt_b", 64'(if_b.stallCnt), 64'(scnt_b));
      check_eq("fwdCnt_b", 64'(if_b.fwdCnt), 64'(fcnt_b));
   endtask

   task automatic step();
      cmp_now();
      tick();
   endtask

   task automatic apply_reset();
      Rst = 1'b0;
      left_a = 0; left_b = 0;
      scnt_a = 0; fcnt_a = 0; scnt_b = 0; fcnt_b = 0;
      #1;
      check_eq("rst_stall_a", 64'(if_a.stall), 64'd0);
      check_eq("rst_stall_b", 64'(if_b.stall), 64'd0);
      check_eq("rst_bubble_b", 64'(if_b.bubble), 64'd0);
      check_eq("rst_stallCnt_b", 64'(if_b.stallCnt), 64'd0);
      check_eq("rst_fwdCnt_a", 64'(if_a.fwdCnt), 64'd0);
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end

   initial begin
      ops = '{6'h23, 6'h20, 6'h21, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
              6'h00, 6'h1C, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02, 6'h3F};
      n_total = 0;
      n_bad   = 0;
      Rst = 1'b0;
      ex_instr = '0; id_instr = '0; dest_vec = '0; rw_vec = '0; res_vec = '0;
      ex_dest = '0; ex_mem_read = 1'b0; cnt_clear = 1'b0;
      apply_reset();

      // Forward priority: stage 0 beats stage 1
      ex_instr = 32'h0022_1820;
      dest_vec = {5'd0, 5'd1, 5'd1};
      rw_vec   = 3'b011;
      res_vec  = {32'h0, 32'hBBBB, 32'hAAAA};
      cmp_now();
      check_eq("t1_selA", 64'(if_a.fwdSelA), 64'd1);
      check_eq("t1_valA", 64'(if_a.fwdValA), 64'hAAAA);
      check_eq("t1_selB", 64'(if_a.fwdSelB), 64'd0);
      check_eq("t1_valB", 64'(if_a.fwdValB), 64'd0);
      tick();

      // rs = $0 never forwards; a disabled stage never forwards
      ex_instr = {6'h08, 5'd0, 5'd3, 16'h0001};
      dest_vec = {5'd0, 5'd0, 5'd0};
      rw_vec   = 3'b001;
      cmp_now();
      check_eq("t2_zero_selA", 64'(if_b.fwdSelA), 64'd0);
      tick();
      ex_instr = {6'h08, 5'd4, 5'd3, 16'h0001};
      dest_vec = {5'd0, 5'd0, 5'd4};
      rw_vec   = 3'b000;
      cmp_now();
      check_eq("t2_nowr_selA", 64'(if_b.fwdSelA), 64'd0);
      tick();

      // Load-use stall: sub $7,$6,$5 after a load into $5
      ex_mem_read = 1'b1;
      ex_dest     = 5'd5;
      id_instr    = {6'h00, 5'd6, 5'd5, 5'd7, 5'd0, 6'h22};
      cmp_now();
      check_eq("t3_stall_a1", 64'(if_a.stall), 64'd1);
      check_eq("t3_bubble_a1", 64'(if_a.bubble), 64'd1);
      tick();
      ex_mem_read = 1'b0;
      cmp_now();
      check_eq("t3_stall_a2", 64'(if_a.stall), 64'd0);
      check_eq("t4_stall_b2", 64'(if_b.stall), 64'd1);
      tick();
      cmp_now();
      check_eq("t4_stall_b3", 64'(if_b.stall), 64'd1);
      tick();
      cmp_now();
      check_eq("t4_stall_b4", 64'(if_b.stall), 64'd0);
      tick();
      check_eq("t3_stallCnt_a", 64'(if_a.stallCnt), 64'd1);
      check_eq("t4_stallCnt_b", 64'(if_b.stallCnt), 64'd3);

      // lw only reads rs, so rt == exDest is not a hazard
      ex_mem_read = 1'b1;
      id_instr    = {6'h23, 5'd9, 5'd5, 16'h0010};
      cmp_now();
      check_eq("t4_lw_stall_a", 64'(if_a.stall), 64'd0);
      check_eq("t4_lw_stall_b", 64'(if_b.stall), 64'd0);
      tick();

      // Reset in the second cycle of a 3-cycle stall
      id_instr = {6'h00, 5'd6, 5'd5, 5'd7, 5'd0, 6'h22};
      step();
      ex_mem_read = 1'b0;
      cmp_now();
      check_eq("t5_pre_stall_b", 64'(if_b.stall), 64'd1);
      apply_reset();
      rw_vec = '0;
      repeat (3) step();
      check_eq("t5_post_stall_b", 64'(if_b.stall), 64'd0);
      check_eq("t5_post_stallCnt_b", 64'(if_b.stallCnt), 64'd0);
      check_eq("t5_post_fwdCnt_b", 64'(if_b.fwdCnt), 64'd0);

      // Saturation at CNT_W=4, then clear while forwarding stays active
      ex_instr = 32'h0022_1820;
      dest_vec = {5'd0, 5'd0, 5'd1};
      rw_vec   = 3'b001;
      repeat (20) step();
      check_eq("t6_sat_fwdCnt_b", 64'(if_b.fwdCnt), 64'd15);
      check_eq("t6_fwdCnt_a", 64'(if_a.fwdCnt), 64'd20);
      cnt_clear = 1'b1;
      step();
      check_eq("t6_clr_fwdCnt_b", 64'(if_b.fwdCnt), 64'd0);
      check_eq("t6_clr_fwdCnt_a", 64'(if_a.fwdCnt), 64'd0);
      cnt_clear = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         ex_instr = {ops[$urandom_range(0, 16)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'($urandom)};
         id_instr = {ops[$urandom_range(0, 16)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'($urandom)};
         for (int k = 0; k < NF; k++) begin
            dest_vec[k*RW +: RW] = 5'($urandom_range(0, 7));
            res_vec[k*DW +: DW]  = $urandom;
         end
         rw_vec      = 3'($urandom);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         ex_dest     = 5'($urandom_range(0, 7));
         cnt_clear   = ($urandom_range(0, 31) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
